// File: rtl/door_open_ctrl_if.sv
// Signal bundle of the door-open stage: car/button requests and the close-stage
// return come in, the door drive, close prompt and status go out.
`timescale 1ns/1ps
interface door_open_ctrl_if;
    logic arrive;
    logic r;
    logic close_signal;
    logic open_signal;
    logic c_100;
    logic busy;
    logic fault;

    modport master (
        output arrive,
        output r,
        output close_signal,
        input  open_signal,
        input  c_100,
        input  busy,
        input  fault
    );

    modport slave (
        input  arrive,
        input  r,
        input  close_signal,
        output open_signal,
        output c_100,
        output busy,
        output fault
    );
endinterface

// File: rtl/door_open_ctrl.sv
// Door-open stage: open drive pulse, dwell, close prompt and close-stage tracking.
// Build option DOOR_REOPEN_EN: the open button reopens the door while it is closing.
`timescale 1ns/1ps
module door_open_ctrl #(
    parameter int unsigned OPEN_CYC  = 8,
    parameter int unsigned DWELL     = 100,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GUARD     = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    door_open_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPENING = 3'd1,
        S_HOLD    = 3'd2,
        S_PULSE   = 3'd3,
        S_CLOSE_A = 3'd4,
        S_CLOSE_B = 3'd5
    } state_t;

    // Counter starts at 0 on state entry, so the terminal value is N-1 for an N-cycle stay.
    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             w_cnt_clr;
    logic             w_fault_set;
    logic             w_reopen;
    logic             w_open_d;
    logic             w_c100_d;
    logic             w_busy_d;
    logic             w_fault_d;
    logic             r_open;
    logic             r_c100;
    logic             r_busy;
    logic             r_fault;

`ifdef DOOR_REOPEN_EN
    assign w_reopen = bus.r;
`else
    assign w_reopen = 1'b0;
`endif

    // State register, shared dwell/guard counter and the one-cycle request pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (r_state == S_IDLE) && (bus.arrive || bus.r);
            if ((w_next != r_state) || w_cnt_clr) begin
                r_cnt <= CNT_ZERO;
            end else if ((r_state != S_IDLE) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Next-state decision, dwell restart and guard-expiry detection.
    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_req) begin
                    w_next = S_OPENING;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_OPENING: begin
                if (r_cnt == OPEN_LAST) begin
                    w_next = S_HOLD;
                end else begin
                    w_next = S_OPENING;
                end
            end
            S_HOLD: begin
                if (bus.r) begin
                    w_next    = S_HOLD;
                    w_cnt_clr = 1'b1;
                end else if (r_cnt == DWELL_LAST) begin
                    w_next = S_PULSE;
                end else begin
                    w_next = S_HOLD;
                end
            end
            S_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_next = S_CLOSE_A;
                end else begin
                    w_next = S_PULSE;
                end
            end
            S_CLOSE_A: begin
                if (w_reopen) begin
                    w_next = S_OPENING;
                end else if (bus.close_signal) begin
                    w_next = S_CLOSE_B;
                end else if (r_cnt == GUARD_LAST) begin
                    w_next      = S_IDLE;
                    w_fault_set = 1'b1;
                end else begin
                    w_next = S_CLOSE_A;
                end
            end
            S_CLOSE_B: begin
                if (w_reopen) begin
                    w_next = S_OPENING;
                end else if (!bus.close_signal) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_CLOSE_B;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output values derived from the state being entered, so they switch with the state.
    always_comb begin
        w_open_d  = (w_next == S_OPENING);
        w_c100_d  = (w_next == S_PULSE);
        w_busy_d  = (w_next != S_IDLE);
        w_fault_d = r_fault || w_fault_set;
    end

    // Output registers; fault is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open  <= 1'b0;
            r_c100  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_open  <= w_open_d;
            r_c100  <= w_c100_d;
            r_busy  <= w_busy_d;
            r_fault <= w_fault_d;
        end
    end

    assign bus.open_signal = r_open;
    assign bus.c_100       = r_c100;
    assign bus.busy        = r_busy;
    assign bus.fault       = r_fault;
endmodule

// File: tb/tb_door_open_ctrl.sv
// Scoreboard bench for door_open_ctrl: expected output change events are derived
// from sequence timing arithmetic and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_door_open_ctrl;
    localparam int O  = 8;
    localparam int D  = 100;
    localparam int PC = 2;
    localparam int G  = 64;

    typedef struct {
        int         edge_n;
        logic [3:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_idle = 0;
    bit   exp_fault = 1'b0;
    ev_t  exp_q[$];
    int   r_list[$];
    int   restart_rel[$];

    door_open_ctrl_if dif();

    door_open_ctrl #(
        .OPEN_CYC (O),
        .DWELL    (D),
        .PULSE_CYC(PC),
        .GUARD    (G),
        .CNT_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] out_vec();
        return {dif.fault, dif.busy, dif.c_100, dif.open_signal};
    endfunction

    function automatic bit in_list(input int e);
        foreach (r_list[k]) begin
            if (r_list[k] == e) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_ev(input int en, input logic [3:0] v);
        ev_t ev;
        ev.edge_n = en;
        ev.vec    = v;
        exp_q.push_back(ev);
    endtask

    // Monitor: every change of the output vector must match the next expected event.
    initial begin
        logic [3:0] prev_vec;
        logic [3:0] v;
        ev_t        ev;
        prev_vec = 4'b0000;
        forever begin
            @(negedge clk);
            v = out_vec();
            if (v !== prev_vec) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: edge %0d got {fault,busy,c_100,open}=%b, no change expected", cyc, v);
                end else begin
                    ev = exp_q.pop_front();
                    if ((ev.edge_n != cyc) || (ev.vec !== v)) begin
                        n_bad++;
                        $display("FAIL event: got edge %0d vec %b, expected edge %0d vec %b", cyc, v, ev.edge_n, ev.vec);
                    end
                end
                prev_vec = v;
            end
        end
    end

    // One open/dwell/prompt/close sequence. trig bit0 = arrive, bit1 = r.
    task automatic run_seq(input int gap, input int trig, input bit respond, input int d1,
                           input int d2, input bit r_thru, input bit noise, input bit rst_mid);
        int N, H0, P, C, I, rs, e, last_e;
        N  = last_idle + gap;
        H0 = N + 1 + O;
        P  = H0 + D;
        r_list.delete();
        foreach (restart_rel[k]) begin
            e = N + restart_rel[k];
            r_list.push_back(e);
            if ((e > H0) && (e <= P)) P = e + D;
        end
        restart_rel.delete();
        C = P + PC;
        if (noise) begin
            r_list.push_back(N + 1 + $urandom_range(0, O - 1));
            r_list.push_back(P + $urandom_range(1, PC));
        end
        if (trig[1]) r_list.push_back(N);
        I  = respond ? (C + d1 + d2) : (C + G);
        rs = r_thru ? (C + $urandom_range(1, I - C)) : I + 1;

        push_ev(N + 1, {exp_fault, 1'b1, 1'b0, 1'b1});
        push_ev(H0,    {exp_fault, 1'b1, 1'b0, 1'b0});
        push_ev(P,     {exp_fault, 1'b1, 1'b1, 1'b0});
        if (!rst_mid) begin
            push_ev(C, {exp_fault, 1'b1, 1'b0, 1'b0});
            if (!respond) exp_fault = 1'b1;
            push_ev(I, {exp_fault, 1'b0, 1'b0, 1'b0});
        end

        last_e = rst_mid ? (P + 1) : I;
        do begin
            @(negedge clk);
            e = cyc + 1;
            dif.arrive       = trig[0] && (e == N);
            dif.r            = in_list(e) || (e >= rs);
            dif.close_signal = respond && (e >= C + d1) && (e < C + d1 + d2);
        end while (e < last_e);

        if (rst_mid) begin
            @(posedge clk);
            push_ev(P + 1, 4'b0000);
            #2 rst = 1'b1;
            exp_fault = 1'b0;
            dif.arrive = 1'b0;
            dif.r = 1'b0;
            dif.close_signal = 1'b0;
            #1;
            n_cmp++;
            if (out_vec() !== 4'b0000) begin
                n_bad++;
                $display("FAIL async_reset: got %b, required 0000", out_vec());
            end
            repeat (3) @(negedge clk);
            rst = 1'b0;
            last_idle = cyc + 1;
        end else begin
            last_idle = I;
        end
    endtask

    initial begin
        bit prev_thru;
        bit thru;
        int k;
        int base;
        dif.arrive = 1'b0;
        dif.r = 1'b0;
        dif.close_signal = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_vec() !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_state: got %b, required 0000", out_vec());
        end
        rst = 1'b0;
        last_idle = cyc + 1;

        // Nominal sequence with a responding close stage.
        run_seq(1, 1, 1'b1, 7, 31, 1'b0, 1'b0, 1'b0);
        // Dwell restart by r 50 cycles after arrive.
        restart_rel.push_back(50);
        run_seq(3, 1, 1'b1, 12, 20, 1'b0, 1'b0, 1'b0);
        // Close stage never answers: fault, then fault persists.
        run_seq(2, 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        run_seq(2, 2, 1'b1, 5, 9, 1'b0, 1'b0, 1'b0);
        // Simultaneous arrive and r, then r held during closing.
        prev_thru = 1'b0;
`ifndef DOOR_REOPEN_EN
        run_seq(1, 3, 1'b1, 3, 15, 1'b1, 1'b0, 1'b0);
        run_seq(1, 2, 1'b1, G, 4, 1'b0, 1'b0, 1'b0);
`endif
        for (int n = 0; n < 14; n++) begin
            k = $urandom_range(0, 2);
            base = O + 1;
            for (int j = 0; j < k; j++) begin
                base = base + $urandom_range(1, D);
                restart_rel.push_back(base);
            end
            thru = 1'b0;
`ifndef DOOR_REOPEN_EN
            thru = ($urandom_range(0, 3) == 0);
`endif
            if (prev_thru) begin
                run_seq(1, $urandom_range(2, 3), ($urandom_range(0, 3) != 0), $urandom_range(1, G),
                        $urandom_range(1, 40), thru, $urandom_range(0, 1), 1'b0);
            end else begin
                run_seq($urandom_range(1, 5), $urandom_range(1, 3), ($urandom_range(0, 3) != 0),
                        $urandom_range(1, G), $urandom_range(1, 40), thru, $urandom_range(0, 1), 1'b0);
            end
            prev_thru = thru;
        end
        if (prev_thru) begin
            run_seq(1, 2, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
        end
        // Reset in the middle of the close prompt, then nominal timing again.
        run_seq(2, 1, 1'b1, 7, 31, 1'b0, 1'b0, 1'b1);
        run_seq(1, 1, 1'b1, 7, 31, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        dif.arrive = 1'b0;
        dif.r = 1'b0;
        dif.close_signal = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d expected changes never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/door_open_ctrl.md
# door_open_ctrl

- Upstream neighbour of the door-close stage in the elevator door path.
- On a floor-arrival pulse or an open-button press, issues the `open_signal` drive pulse, then holds the door open for a dwell period.
- Emits the `c_100` close-prompt pulse; its falling edge tells the close stage it may shut the door.
- Tracks the returned `close_signal` until the close cycle completes.

## Interface
Parameters:
- OPEN_CYC, 8, cycles `open_signal` is held high per open command (≥1)
- DWELL, 100, door-open dwell in cycles before the close prompt (≥1)
- PULSE_CYC, 2, `c_100` high width in cycles (≥1)
- GUARD, 64, max cycles to wait for `close_signal` to rise before declaring a fault (≥1)
- CNT_W, 8, shared counter width; must hold max(OPEN_CYC, DWELL, PULSE_CYC, GUARD)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- arrive  in  1  car-stopped-at-floor pulse, synchronous to clk
- r  in  1  open-button request, synchronised upstream, level
- close_signal  in  1  close drive returned by the close stage
- open_signal  out  1  door-open drive to motor and close stage
- c_100  out  1  close-prompt pulse; falling edge permits closing
- busy  out  1  high whenever state ≠ IDLE
- fault  out  1  sticky: close stage never responded within GUARD

## Operation
- All outputs registered; reset value 0 for every output; state IDLE; counter 0.
- FSM states and behaviour:
  - IDLE: arrive | r → OPENING, counter cleared. Simultaneous arrive and r gives one open sequence.
  - OPENING: `open_signal`=1. When the counter reaches OPEN_CYC → HOLD. r is ignored.
  - HOLD: `open_signal`=0. Counter runs to DWELL → PULSE. r sampled high resets the counter to 0 (dwell restart, unlimited times).
  - PULSE: `c_100`=1 for PULSE_CYC cycles → CLOSING with `c_100`=0. r is ignored.
  - CLOSING, phase A (waiting for `close_signal` rise):
    - Rise → phase B.
    - GUARD cycles elapse without rise → set `fault` → IDLE.
  - CLOSING, phase B (waiting for `close_signal` fall): fall → IDLE.
  - CLOSING and r: see Configuration.
- Counter: single CNT_W-bit up-counter, cleared on every state entry. It never wraps; terminal compare is by equality.
- `fault` is cleared only by rst.
- rst mid-sequence: outputs drop to 0 asynchronously and the FSM is in IDLE. A pending `c_100` pulse is truncated.

## Timing
- arrive sampled high at edge N:
  - `open_signal` high from edge N+1 to edge N+1+OPEN_CYC.
  - `c_100` rises at edge N+1+OPEN_CYC+DWELL and falls PULSE_CYC edges later.
- Latency from request to `open_signal` is 1 cycle.
- `c_100` falls on the same edge the FSM enters CLOSING.
- The GUARD count starts on that edge.
- `busy` follows the state register (same edge as the state change).

## Configuration
- DOOR_REOPEN_EN defined:
  - r high in CLOSING (either phase) → OPENING next edge, `open_signal` reasserted for OPEN_CYC cycles.
  - The close stage then aborts on the `open_signal` rise.
  - GUARD tracking is discarded.
- DOOR_REOPEN_EN undefined:
  - r ignored in CLOSING; the door completes closing.
  - r is serviced only once back in IDLE.

## Test plan
- Defaults, arrive at edge 0 → `open_signal` high edges 1–9 (falls at 9), `c_100` high edges 109–111, `busy` high from edge 1.
- r pulse at edge 50 during HOLD → dwell restarts; `c_100` rises at edge 150 instead of 109.
- Model close stage asserts `close_signal` 7 cycles after the `c_100` fall and drops it 31 cycles later → IDLE, `busy`=0, `fault`=0.
- `close_signal` held 0 after the `c_100` fall → `fault`=1 exactly 64 cycles later, then IDLE. `fault` stays 1 across a new arrive and clears only on rst.
- r during phase B:
  - With DOOR_REOPEN_EN: `open_signal` rises on the next edge for 8 cycles.
  - Without it: ignored until IDLE, then a new sequence starts.
- rst asserted mid-PULSE → `c_100`, `open_signal`, `busy` all 0 immediately. After release, arrive gives the nominal timing from the first test.
